psum_accumulator: RTL

Downstream consumer of the PE array's partial-sum stream. It accumulates one tile of signed partial sums across all input-channel passes, and on the final channel pass applies round/shift/saturate to produce output-feature-map bytes. Results are buffered in a small FIFO behind a valid/ready port toward the output writer. The PE stream cannot stall, so FIFO overflow drops data and raises a sticky error.

---
 rtl/psum_accumulator_pkg.sv | 61 ++++++
 rtl/psum_accumulator_if.sv | 12 +
 rtl/psum_accumulator_fifo.sv | 53 +++++
 rtl/psum_accumulator.sv | 134 +++++++++++++
 4 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared widths, FIFO entry payload and arithmetic helpers for psum_accumulator.
// Optional feature macro: PSUM_RELU_EN (negative sums quantize to zero).
package acc_pkg;

  localparam int unsigned TILE_LEN   = 16;
  localparam int unsigned PSUM_W     = 24;
  localparam int unsigned ACC_W      = 32;
  localparam int unsigned OUT_W      = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  // Output clamp bounds at the widened quantizer width
  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] Q_MIN = ~Q_MAX;

  typedef struct packed {
    logic                    last;
    logic signed [OUT_W-1:0] data;
  } fifo_entry_t;

  typedef struct packed {
    logic                    sat;
    logic signed [ACC_W-1:0] val;
  } sat_res_t;

  // Signed add clamped to the accumulator range; sat flags any clamp
  function automatic sat_res_t sat_acc(input logic signed [ACC_W-1:0] a,
                                       input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    sat_res_t r;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    r.sat = (s[ACC_W] != s[ACC_W-1]);
    if (!r.sat)
      r.val = s[ACC_W-1:0];
    else if (s[ACC_W])
      r.val = {1'b1, {(ACC_W-1){1'b0}}};
    else
      r.val = {1'b0, {(ACC_W-1){1'b1}}};
    return r;
  endfunction

  // Round-half-up arithmetic right shift, then clamp to the output range
  function automatic logic signed [OUT_W-1:0] round_shift_sat(input logic signed [ACC_W-1:0] sum,
                                                               input logic [4:0] shift);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] q;
    ext = {sum[ACC_W-1], sum};
`ifdef PSUM_RELU_EN
    if (ext[ACC_W]) ext = '0;
`endif
    rnd = (shift != 5'd0) ? ((ACC_W+1)'(1) << (shift - 5'd1)) : '0;
    q   = (ext + rnd) >>> shift;
    if (q > Q_MAX)
      return Q_MAX[OUT_W-1:0];
    else if (q < Q_MIN)
      return Q_MIN[OUT_W-1:0];
    else
      return q[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Valid/ready result port toward the output writer.
interface psum_accumulator_if #(
  parameter int unsigned OUT_W = acc_pkg::OUT_W
);
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/psum_accumulator_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module psum_out_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  // Status flags, accepted operations and head word
  always_comb begin
    empty_c   = (wr_ptr == rd_ptr);
    full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop_c  = pop && !empty_c;
    do_push_c = push && (!full_c || do_pop_c);
    rdata_c   = mem[rd_ptr[AW-1:0]];
  end

  // Read/write pointers with wrap bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop_c)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage; contents are only observed behind a non-empty head
  always_ff @(posedge clk) begin
    if (do_push_c && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a tile of partial sums over channel passes and quantizes the
// final pass into a result FIFO. Optional macro: PSUM_RELU_EN.
module psum_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned TILE_LEN   = acc_pkg::TILE_LEN,
  parameter int unsigned PSUM_W     = acc_pkg::PSUM_W,
  parameter int unsigned ACC_W      = acc_pkg::ACC_W,
  parameter int unsigned OUT_W      = acc_pkg::OUT_W,
  parameter int unsigned FIFO_DEPTH = acc_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_conv,
  input  logic [4:0]               cfg_shift,
  input  logic                     p_valid,
  input  logic                     last_chanel,
  input  logic signed [PSUM_W-1:0] psum_in,
  input  logic                     end_conv,
  psum_accumulator_if.master       out_if,
  output logic                     acc_sat,
  output logic                     ovf_err,
  output logic                     done
);
  localparam int unsigned    IDX_W    = $clog2(TILE_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TILE_LEN - 1);

  logic [4:0]              shift_q;
  logic [IDX_W-1:0]        idx;
  logic                    first_pass;
  logic signed [ACC_W-1:0] acc_mem [TILE_LEN];
  logic                    q_valid;
  fifo_entry_t             q_entry;
  logic                    pending_done;

  logic                    beat_c;
  logic signed [ACC_W-1:0] psum_ext_c;
  sat_res_t                add_c;
  logic signed [ACC_W-1:0] sum_c;
  logic                    done_c;
  logic                    fifo_full_c;
  logic                    fifo_empty_c;
  logic                    fifo_pop_c;
  fifo_entry_t             head_c;

  // Beat qualification and the running sum for the current entry
  always_comb begin
    beat_c     = p_valid && !start_conv;
    psum_ext_c = {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
    add_c      = sat_acc(acc_mem[idx], psum_ext_c);
    sum_c      = first_pass ? psum_ext_c : add_c.val;
    fifo_pop_c = out_if.out_valid && out_if.out_ready;
    done_c     = pending_done && !q_valid && fifo_empty_c;
  end

  // Entry index, pass tracking and latched shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      idx        <= '0;
      first_pass <= 1'b1;
    end else if (start_conv) begin
      shift_q    <= cfg_shift;
      idx        <= '0;
      first_pass <= 1'b1;
    end else if (p_valid) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (idx == IDX_LAST) first_pass <= last_chanel;
    end
  end

  // Accumulator array; first pass overwrites so no reset is needed
  always_ff @(posedge clk) begin
    if (beat_c && !last_chanel) acc_mem[idx] <= sum_c;
  end

  // Quantizer register feeding the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_entry <= '0;
    end else if (start_conv) begin
      q_valid <= 1'b0;
    end else begin
      q_valid <= p_valid && last_chanel;
      if (p_valid && last_chanel) begin
        q_entry.last <= (idx == IDX_LAST);
        q_entry.data <= round_shift_sat(sum_c, shift_q);
      end
    end
  end

  // Sticky error flags and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sat      <= 1'b0;
      ovf_err      <= 1'b0;
      pending_done <= 1'b0;
      done         <= 1'b0;
    end else if (start_conv) begin
      acc_sat      <= 1'b0;
      ovf_err      <= 1'b0;
      pending_done <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (beat_c && !first_pass && add_c.sat) acc_sat <= 1'b1;
      if (q_valid && fifo_full_c && !fifo_pop_c) ovf_err <= 1'b1;
      done <= done_c;
      if (end_conv)    pending_done <= 1'b1;
      else if (done_c) pending_done <= 1'b0;
    end
  end

  psum_out_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_conv),
    .push    (q_valid),
    .pop     (fifo_pop_c),
    .wdata   (q_entry),
    .rdata_c (head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Head of FIFO presented with zeroed payload while empty
  assign out_if.out_valid = !fifo_empty_c;
  assign out_if.out_data  = fifo_empty_c ? '0 : OUT_W'(head_c.data);
  assign out_if.out_last  = !fifo_empty_c && head_c.last;

endmodule
